// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
// Decode->execute immediate generator. Each accepted instruction word is turned
// into an XLEN-wide immediate (I/S/B/U/J formats, CSR zimm, shift amount, or an
// illegal-type marker). The result is registered in an output register backed by
// a one-entry skid register, so back-pressure from EX never creates a
// combinational path from out_ready to in_ready.
//
// Parameters
//   XLEN   immediate width, 32 or 64
//   TAG_W  sideband tag width, carried unchanged alongside each immediate
//
// Ports
//   clk        core clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous flush; empties both entries and drops the input
//   in_valid   instr / imm_type / in_tag are valid
//   in_ready   stage can accept (driven only by the skid-full flop)
//   instr      32-bit instruction word
//   imm_type   000 I, 001 S, 101 B, 010 U, 110 J, 011 Z, 100 SH, 111 illegal
//   in_tag     sideband tag
//   out_valid  imm_out / out_tag / illegal are valid
//   out_ready  consumer accepts this cycle
//   imm_out    generated immediate
//   out_tag    tag paired with imm_out
//   illegal    imm_type was 111 (imm_out is then 0)
// -----------------------------------------------------------------------------
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  localparam logic [2:0] TYPE_I   = 3'b000;
  localparam logic [2:0] TYPE_S   = 3'b001;
  localparam logic [2:0] TYPE_U   = 3'b010;
  localparam logic [2:0] TYPE_Z   = 3'b011;
  localparam logic [2:0] TYPE_SH  = 3'b100;
  localparam logic [2:0] TYPE_B   = 3'b101;
  localparam logic [2:0] TYPE_J   = 3'b110;
  localparam logic [2:0] TYPE_ILL = 3'b111;

  // Output register (O)
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             ill_q, ill_d;

  // Skid register (S)
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_ill_q, skid_ill_d;

  // Freshly formed immediate for the word on the input
  logic [31:0]      imm32;
  logic [XLEN-1:0]  new_imm;
  logic             new_ill;

  logic             accept;

  // The opcode field never contributes to any immediate.
  logic             unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // Every format is first built as a 32-bit value. The zero-extended formats
  // (Z, SH, illegal) always have bit 31 clear, so one signed widening to XLEN
  // serves both the sign- and zero-extended cases.
  always_comb begin
    imm32   = '0;
    new_ill = 1'b0;
    case (imm_type)
      TYPE_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
      TYPE_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      TYPE_B:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      TYPE_U:  imm32 = {instr[31:12], 12'b0};
      TYPE_J:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      TYPE_Z:  imm32 = {27'b0, instr[19:15]};
      TYPE_SH: begin
        if (XLEN == 64) imm32 = {26'b0, instr[25:20]};
        else            imm32 = {27'b0, instr[24:20]};
      end
      TYPE_ILL: new_ill = 1'b1;
      default:  imm32 = '0;
    endcase
    new_imm = XLEN'($signed(imm32));
  end

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && !skid_valid_q;

  // While S is full in_ready is low, so the only possible move is S into O
  // when the consumer takes O. With S empty, a new word goes to O if O is
  // empty or draining this cycle, and otherwise parks in S.
  always_comb begin
    out_valid_d  = out_valid_q;
    imm_d        = imm_q;
    tag_d        = tag_q;
    ill_d        = ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_ready) begin
        out_valid_d  = 1'b1;
        imm_d        = skid_imm_q;
        tag_d        = skid_tag_q;
        ill_d        = skid_ill_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        imm_d       = new_imm;
        tag_d       = in_tag;
        ill_d       = new_ill;
      end else begin
        skid_valid_d = 1'b1;
        skid_imm_d   = new_imm;
        skid_tag_d   = in_tag;
        skid_ill_d   = new_ill;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      imm_q        <= '0;
      tag_q        <= '0;
      ill_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      imm_q        <= imm_d;
      tag_q        <= tag_d;
      ill_q        <= ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign out_valid = out_valid_q;
  assign imm_out   = imm_q;
  assign out_tag   = tag_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_stage
// Directed bench for imm_gen_stage. Two instances share all inputs: one built
// with XLEN=32 and one with XLEN=64, so every vector checks both widths.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_imm_gen_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_type;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm_out32, out_tag32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm_out64;
  logic [31:0] out_tag64;

  int checks;
  int failures;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_type(imm_type), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .imm_out(imm_out32), .out_tag(out_tag32), .illegal(illegal32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_type(imm_type), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .imm_out(imm_out64), .out_tag(out_tag64), .illegal(illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  // Advances one clock and leaves time 1 unit past the rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] word,
                               input logic [2:0] kind, input logic [31:0] tag);
    in_valid = valid;
    instr    = word;
    imm_type = kind;
    in_tag   = tag;
  endtask

  // Sends one word with out_ready high and checks the result one cycle later
  // on both widths, then checks that the output drains.
  task automatic sendOne(input string name, input logic [31:0] word,
                         input logic [2:0] kind, input logic [31:0] tag,
                         input logic [31:0] exp32, input logic [63:0] exp64,
                         input logic expIll);
    applyStimulus(1'b1, word, kind, tag);
    stepClock();
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    checkOutput({name, "_valid32"}, {63'b0, out_valid32}, 64'd1);
    checkOutput({name, "_imm32"}, {32'b0, imm_out32}, {32'b0, exp32});
    checkOutput({name, "_imm64"}, imm_out64, exp64);
    checkOutput({name, "_tag"}, {32'b0, out_tag32}, {32'b0, tag});
    checkOutput({name, "_ill32"}, {63'b0, illegal32}, {63'b0, expIll});
    checkOutput({name, "_ill64"}, {63'b0, illegal64}, {63'b0, expIll});
    stepClock();
    checkOutput({name, "_drain"}, {63'b0, out_valid64}, 64'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);

    #12;
    checkOutput("rst_valid", {63'b0, out_valid32}, 64'd0);
    checkOutput("rst_in_ready", {63'b0, in_ready32}, 64'd1);
    checkOutput("rst_imm64", imm_out64, 64'd0);
    checkOutput("rst_tag", {32'b0, out_tag32}, 64'd0);
    checkOutput("rst_ill", {63'b0, illegal32}, 64'd0);
    rst_n = 1'b1;
    stepClock();

    // Formats
    sendOne("i_neg",  32'hFFF00093, 3'b000, 32'h11, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    sendOne("i_pos",  32'h00500093, 3'b000, 32'h12, 32'h00000005, 64'h0000000000000005, 1'b0);
    sendOne("j_neg",  32'hFFDFF06F, 3'b110, 32'h13, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    sendOne("s_neg",  32'hFE000FA3, 3'b001, 32'h14, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    sendOne("s_pos",  32'h00A12423, 3'b001, 32'h15, 32'h00000008, 64'h0000000000000008, 1'b0);
    sendOne("b_neg",  32'h80000063, 3'b101, 32'h16, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0);
    sendOne("u_neg",  32'h80000037, 3'b010, 32'h17, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
    sendOne("u_pos",  32'h12345037, 3'b010, 32'h18, 32'h12345000, 64'h0000000012345000, 1'b0);
    sendOne("z_max",  32'h800F8073, 3'b011, 32'h19, 32'h0000001F, 64'h000000000000001F, 1'b0);
    sendOne("sh_max", 32'h83F00013, 3'b100, 32'h1A, 32'h0000001F, 64'h000000000000003F, 1'b0);
    sendOne("ill",    32'hFFFFFFFF, 3'b111, 32'h1B, 32'h00000000, 64'h0000000000000000, 1'b1);

    // Back-pressure: immediate value equals the tag (addi with imm=tag).
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00100093, 3'b000, 32'd1);
    stepClock();
    checkOutput("bp_o1_tag", {32'b0, out_tag32}, 64'd1);
    checkOutput("bp_ready_after1", {63'b0, in_ready32}, 64'd1);
    applyStimulus(1'b1, 32'h00200093, 3'b000, 32'd2);
    stepClock();
    checkOutput("bp_ready_after2", {63'b0, in_ready32}, 64'd0);
    checkOutput("bp_hold_tag", {32'b0, out_tag32}, 64'd1);
    applyStimulus(1'b1, 32'h00300093, 3'b000, 32'd3);
    stepClock();
    checkOutput("bp_stall_tag", {32'b0, out_tag32}, 64'd1);
    checkOutput("bp_stall_imm", imm_out64, 64'd1);
    checkOutput("bp_stall_ready", {63'b0, in_ready64}, 64'd0);
    out_ready = 1'b1;
    stepClock();
    checkOutput("bp_second_tag", {32'b0, out_tag32}, 64'd2);
    checkOutput("bp_second_imm", {32'b0, imm_out32}, 64'd2);
    checkOutput("bp_ready_again", {63'b0, in_ready32}, 64'd1);
    stepClock();
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    checkOutput("bp_third_tag", {32'b0, out_tag32}, 64'd3);
    checkOutput("bp_third_valid", {63'b0, out_valid32}, 64'd1);
    stepClock();
    checkOutput("bp_empty", {63'b0, out_valid32}, 64'd0);

    // Flush with O and S full; tag 9 presented on the flush cycle.
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00400093, 3'b000, 32'd4);
    stepClock();
    applyStimulus(1'b1, 32'h00500093, 3'b000, 32'd5);
    stepClock();
    checkOutput("fl_full_ready", {63'b0, in_ready32}, 64'd0);
    applyStimulus(1'b1, 32'h00900093, 3'b000, 32'd9);
    flush = 1'b1;
    stepClock();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    checkOutput("fl_valid", {63'b0, out_valid32}, 64'd0);
    checkOutput("fl_ready", {63'b0, in_ready32}, 64'd1);
    out_ready = 1'b1;
    stepClock();
    checkOutput("fl_stays_empty", {63'b0, out_valid64}, 64'd0);

    // Flush with O full, S empty: tag 9 would otherwise land in S.
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00600093, 3'b000, 32'd6);
    stepClock();
    applyStimulus(1'b1, 32'h00900093, 3'b000, 32'd9);
    flush = 1'b1;
    stepClock();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    checkOutput("fl2_valid", {63'b0, out_valid32}, 64'd0);
    checkOutput("fl2_ready", {63'b0, in_ready32}, 64'd1);
    out_ready = 1'b1;
    stepClock();
    checkOutput("fl2_no_tag9", {63'b0, out_valid32}, 64'd0);

    // Asynchronous reset mid-stream, away from any clock edge.
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'hFFF00093, 3'b000, 32'd7);
    stepClock();
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
    checkOutput("ar_pre_valid", {63'b0, out_valid32}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", {63'b0, out_valid32}, 64'd0);
    checkOutput("ar_imm64", imm_out64, 64'd0);
    checkOutput("ar_tag", {32'b0, out_tag32}, 64'd0);
    checkOutput("ar_ready", {63'b0, in_ready32}, 64'd1);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stepClock();
    checkOutput("ar_idle", {63'b0, out_valid32}, 64'd0);
    sendOne("ar_after", 32'h00700093, 3'b000, 32'd8, 32'h00000007, 64'h0000000000000007, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
